relay_symbol_decoder: RTL and testbench

Parametrised majority-vote bit slicer for the relay receive path: it oversamples the demodulated `data_in` stream, decides one bit per window of `SAMPLES_PER_BIT` samples and emits a per-bit nibble strobe for the existing relay/direct consumers. It also assembles the decided bits into `WORD_BITS`-wide words behind a valid/ready handshake, and detects end-of-frame. It sits between the demodulator and the relay FIFO/ARM-facing logic.

---
 rtl/relay_symbol_decoder.sv | 196 +++++++++++++++++++
 tb/tb_relay_symbol_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : relay_symbol_decoder
// Description : Majority-vote bit slicer for the relay receive path.
//               Oversamples data_in, decides one bit per SAMPLES_PER_BIT
//               window and emits a one-cycle nibble strobe per decided bit.
//               It also packs the decided bits MSB-first into WORD_BITS-wide
//               words behind a valid/ready handshake, and reports end of
//               frame after IDLE_BITS consecutive decided zeros.
// Ports       : clk, reset (sync, active-high)
//               mode            1 = relay mark, 0 = direct mark
//               data_in         oversampled line
//               data_out        per-bit symbol, qualified by data_available
//               data_available  one-cycle strobe per decided bit
//               word_out/word_valid/word_ready  assembled-word handshake
//               overflow        sticky dropped-word flag, cleared by ovf_clear
//               frame_end       one-cycle strobe when the idle run completes
// Options     : RELAY_SYMBOL_DECODER_DEGLITCH_EN adds a 2-of-3 majority
//               filter ahead of the slicer (+2 cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module relay_symbol_decoder #(
  parameter int               SAMPLES_PER_BIT = 64,
  parameter int               OUT_W           = 4,
  parameter logic [OUT_W-1:0] MARK_RELAY      = 4'hc,
  parameter logic [OUT_W-1:0] MARK_DIRECT     = 4'hf,
  parameter int               WORD_BITS       = 8,
  parameter int               IDLE_BITS       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 data_in,
  output logic [OUT_W-1:0]     data_out,
  output logic                 data_available,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overflow,
  input  logic                 ovf_clear,
  output logic                 frame_end
);

  localparam int c_cnt_w  = $clog2(SAMPLES_PER_BIT + 1);
  localparam int c_bcnt_w = $clog2(WORD_BITS + 1);
  // +2 keeps the run counter at least one bit wide when idle detection is off
  localparam int c_run_w  = $clog2(IDLE_BITS + 2);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SAMPLE = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_scnt, w_scnt_nxt, r_ones, w_ones_nxt;
  logic [c_bcnt_w-1:0]  r_bcnt, w_bcnt_nxt;
  logic [c_run_w-1:0]   r_run, w_run_nxt;
  logic [WORD_BITS-1:0] r_shift, w_shift_nxt, r_word_out, w_word_out_nxt;
  logic [OUT_W-1:0]     r_data_out, w_data_out_nxt;
  logic                 r_dav, w_dav_nxt, r_word_valid, w_word_valid_nxt;
  logic                 r_ovf, w_ovf_nxt, r_fe, w_fe_nxt;

  logic                 w_din;
  logic [c_cnt_w-1:0]   w_scnt_inc, w_ones_inc;
  logic [c_cnt_w:0]     w_twice_ones;
  logic [c_run_w-1:0]   w_run_inc;
  logic [WORD_BITS-1:0] w_shifted;
  logic                 w_bit;

`ifdef RELAY_SYMBOL_DECODER_DEGLITCH_EN
  // Majority over three registered taps: two cycles of added latency.
  logic [2:0] r_tap;
  always_ff @(posedge clk) begin
    if (reset) r_tap <= '0;
    else       r_tap <= {r_tap[1:0], data_in};
  end
  assign w_din = (r_tap[0] & r_tap[1]) | (r_tap[0] & r_tap[2]) | (r_tap[1] & r_tap[2]);
`else
  assign w_din = data_in;
`endif

  assign w_scnt_inc   = r_scnt + 1'b1;
  assign w_ones_inc   = r_ones + c_cnt_w'(w_din);
  // 2*ones held one bit wider so the majority compare cannot wrap
  assign w_twice_ones = {w_ones_inc, 1'b0};
  assign w_bit        = w_twice_ones > (c_cnt_w + 1)'(SAMPLES_PER_BIT);
  assign w_shifted    = WORD_BITS'({r_shift, w_bit});
  assign w_run_inc    = r_run + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_scnt_nxt       = r_scnt;
    w_ones_nxt       = r_ones;
    w_bcnt_nxt       = r_bcnt;
    w_run_nxt        = r_run;
    w_shift_nxt      = r_shift;
    w_word_out_nxt   = r_word_out;
    w_word_valid_nxt = r_word_valid & ~word_ready;
    w_ovf_nxt        = r_ovf & ~ovf_clear;
    w_data_out_nxt   = '0;
    w_dav_nxt        = 1'b0;
    w_fe_nxt         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The starting 1 is itself the first sample of the window.
        if (w_din) begin
          w_state_nxt = S_SAMPLE;
          w_scnt_nxt  = c_cnt_w'(1);
          w_ones_nxt  = c_cnt_w'(1);
        end
      end
      S_SAMPLE: begin
        if (w_scnt_inc == c_cnt_w'(SAMPLES_PER_BIT)) begin
          w_scnt_nxt     = '0;
          w_ones_nxt     = '0;
          w_dav_nxt      = 1'b1;
          w_data_out_nxt = w_bit ? (mode ? MARK_RELAY : MARK_DIRECT) : '0;

          if (r_bcnt == c_bcnt_w'(WORD_BITS - 1)) begin
            w_bcnt_nxt  = '0;
            w_shift_nxt = '0;
            if (r_word_valid && !word_ready) begin
              // Holding register still owned by the consumer: drop new word.
              w_ovf_nxt = 1'b1;
            end else begin
              w_word_out_nxt   = w_shifted;
              w_word_valid_nxt = 1'b1;
            end
          end else begin
            w_bcnt_nxt  = r_bcnt + 1'b1;
            w_shift_nxt = w_shifted;
          end

          if (w_bit) begin
            w_run_nxt = '0;
          end else if (IDLE_BITS > 0) begin
            if (w_run_inc == c_run_w'(IDLE_BITS)) begin
              // End of frame discards any partial word but keeps a pending one.
              w_run_nxt   = '0;
              w_fe_nxt    = 1'b1;
              w_state_nxt = S_IDLE;
              w_shift_nxt = '0;
              w_bcnt_nxt  = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end else begin
          w_scnt_nxt = w_scnt_inc;
          w_ones_nxt = w_ones_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_scnt       <= '0;
      r_ones       <= '0;
      r_bcnt       <= '0;
      r_run        <= '0;
      r_shift      <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_data_out   <= '0;
      r_dav        <= 1'b0;
      r_fe         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_scnt       <= w_scnt_nxt;
      r_ones       <= w_ones_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_run        <= w_run_nxt;
      r_shift      <= w_shift_nxt;
      r_word_out   <= w_word_out_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_ovf        <= w_ovf_nxt;
      r_data_out   <= w_data_out_nxt;
      r_dav        <= w_dav_nxt;
      r_fe         <= w_fe_nxt;
    end
  end

  assign data_out       = r_data_out;
  assign data_available = r_dav;
  assign word_out       = r_word_out;
  assign word_valid     = r_word_valid;
  assign overflow       = r_ovf;
  assign frame_end      = r_fe;

endmodule
`default_nettype wire

// File: tb/tb_relay_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_relay_symbol_decoder
// Description : Self-checking bench for relay_symbol_decoder (default build).
//               Expected strobes, words and frame ends are derived from the
//               sample stream by slicing it into windows after each start 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relay_symbol_decoder;

  localparam int          c_spb  = 64;
  localparam int          c_idle = 16;
  localparam logic [3:0]  c_mr   = 4'hc;
  localparam logic [3:0]  c_md   = 4'hf;

  logic       clk = 1'b0;
  logic       reset, mode, data_in, word_ready, ovf_clear;
  logic [3:0] data_out;
  logic       data_available, word_valid, overflow, frame_end;
  logic [7:0] word_out;

  relay_symbol_decoder dut (
    .clk(clk), .reset(reset), .mode(mode), .data_in(data_in),
    .data_out(data_out), .data_available(data_available),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .ovf_clear(ovf_clear), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit         samp[$];
  bit         mds[$];
  bit         exp_av[], exp_fe[], exp_wv[];
  logic [3:0] exp_do[];
  logic [7:0] exp_wo[];

  logic [3:0] got_do[$];
  int         first_av, n_fe, n_wv;
  logic [7:0] last_wo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic push_run(input bit v, input int n, input bit m);
    for (int k = 0; k < n; k++) begin
      samp.push_back(v);
      mds.push_back(m);
    end
  endtask

  task automatic push_bits(input logic [31:0] val, input int nb, input bit m);
    for (int b = nb - 1; b >= 0; b--) push_run(val[b], c_spb, m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in = 1'b0;
    ovf_clear = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Window-slicing reference: after each start 1, consecutive SPB-sample
  // slices are summed; a decision lands on the slice's last sample.
  task automatic build_model();
    int n, i, st, e, ones, run, nb;
    bit b;
    logic [7:0] acc, hold;
    n = samp.size();
    exp_av = new[n]; exp_fe = new[n]; exp_wv = new[n];
    exp_do = new[n]; exp_wo = new[n];
    for (int j = 0; j < n; j++) begin
      exp_av[j] = 0; exp_fe[j] = 0; exp_wv[j] = 0; exp_do[j] = '0; exp_wo[j] = '0;
    end
    i = 0; run = 0; nb = 0; acc = '0;
    while (i < n) begin
      if (!samp[i]) begin
        i++;
        continue;
      end
      st = i;
      forever begin
        e = st + c_spb - 1;
        if (e >= n) begin
          i = n;
          break;
        end
        ones = 0;
        for (int k = st; k <= e; k++) ones += int'(samp[k]);
        b = (2 * ones > c_spb);
        exp_av[e] = 1;
        exp_do[e] = b ? (mds[e] ? c_mr : c_md) : 4'h0;
        acc = {acc[6:0], b};
        nb++;
        if (nb == 8) begin
          exp_wv[e] = 1;
          exp_wo[e] = acc;
          nb = 0;
          acc = '0;
        end
        run = b ? 0 : run + 1;
        if (run == c_idle) begin
          exp_fe[e] = 1;
          run = 0; nb = 0; acc = '0;
          i = e + 1;
          break;
        end
        st = e + 1;
      end
    end
    hold = '0;
    for (int j = 0; j < n; j++) begin
      if (exp_wv[j]) hold = exp_wo[j];
      exp_wo[j] = hold;
    end
  endtask

  task automatic run_seg(input bit chk_word);
    build_model();
    got_do = {};
    first_av = -1; n_fe = 0; n_wv = 0;
    for (int i = 0; i < samp.size(); i++) begin
      data_in = samp[i];
      mode    = mds[i];
      step();
      if (data_available) begin
        got_do.push_back(data_out);
        if (first_av < 0) first_av = i;
      end
      if (frame_end) n_fe++;
      if (word_valid) begin
        n_wv++;
        last_wo = word_out;
      end
      check($sformatf("av@%0d", i), data_available, exp_av[i]);
      check($sformatf("dout@%0d", i), data_out, exp_do[i]);
      check($sformatf("fe@%0d", i), frame_end, exp_fe[i]);
      if (chk_word) begin
        check($sformatf("wv@%0d", i), word_valid, exp_wv[i]);
        check($sformatf("wout@%0d", i), word_out, exp_wo[i]);
        check($sformatf("ovf@%0d", i), overflow, 0);
      end
    end
    samp = {};
    mds = {};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_av"}, data_available, 0);
    check({tag, "_wout"}, word_out, 0);
    check({tag, "_wv"}, word_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_fe"}, frame_end, 0);
  endtask

  initial begin
    int p, t;
    reset = 1'b1; mode = 1'b1; data_in = 1'b0; word_ready = 1'b1; ovf_clear = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // 64 ones then 64 zeros, relay mode
    push_run(1, 64, 1);
    push_run(0, 64, 1);
    run_seg(1);
    check("first_latency", first_av, 63);
    check("t1_nstrobe", got_do.size(), 2);
    check("t1_strobe1", got_do[0], c_mr);
    check("t1_strobe2", got_do[1], 0);

    // exact tie decides 0
    do_reset();
    push_run(1, 32, 1);
    push_run(0, 32, 1);
    run_seg(1);
    check("tie_n", got_do.size(), 1);
    check("tie_val", got_do[0], 0);

    // 33 ones in direct mode
    do_reset();
    push_run(1, 33, 0);
    push_run(0, 31, 0);
    run_seg(1);
    check("direct_n", got_do.size(), 1);
    check("direct_val", got_do[0], c_md);

    // single word A5 with consumer ready
    do_reset();
    push_bits(32'hA5, 8, 1);
    run_seg(1);
    check("a5_nvalid", n_wv, 1);
    check("a5_word", last_wo, 8'hA5);

    // two words without ready -> overflow, held word kept
    do_reset();
    word_ready = 1'b0;
    push_bits(32'hA5, 8, 1);
    push_bits(32'h3C, 8, 1);
    run_seg(0);
    check("ovf_wv", word_valid, 1);
    check("ovf_word", word_out, 8'hA5);
    check("ovf_set", overflow, 1);
    ovf_clear = 1'b1; word_ready = 1'b1; data_in = 1'b0;
    step();
    ovf_clear = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_wv_clr", word_valid, 0);

    // bit 1, 16 zero bits -> frame end, then a clean 1 with no slip
    do_reset();
    word_ready = 1'b1;
    push_bits(32'h10000, 17, 1);
    push_run(1, 64, 1);
    run_seg(1);
    check("fe_count", n_fe, 1);
    check("fe_nstrobe", got_do.size(), 18);
    check("fe_next_bit", got_do[17], c_mr);

    // reset at sample 30 of a window while a word is pending
    do_reset();
    word_ready = 1'b0;
    push_bits(32'hA5, 8, 1);
    run_seg(0);
    check("pre_rst_wv", word_valid, 1);
    push_run(1, 29, 1);
    run_seg(0);
    reset = 1'b1; data_in = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    word_ready = 1'b1;
    push_bits(32'hC3, 8, 1);
    run_seg(1);
    check("post_rst_word", last_wo, 8'hC3);

    // randomized frames with noise, random mode, idle gaps and frame ends
    for (int s = 0; s < 4; s++) begin
      do_reset();
      push_run(0, $urandom_range(100), 1);
      for (int b = 0; b < $urandom_range(40, 20); b++) begin
        t = $urandom_range(9);
        p = (t < 4) ? 85 : (t < 8) ? 15 : 50;
        for (int k = 0; k < c_spb; k++) begin
          samp.push_back($urandom_range(99) < p);
          mds.push_back($urandom_range(1) == 1);
        end
        if ($urandom_range(15) == 0) push_run(0, 17 * c_spb, $urandom_range(1) == 1);
      end
      run_seg(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
